// File: rtl/me_stage_nb_pkg.sv
// me_pkg: shared definitions for the ME stage.
//   ld_size_e     - load size codes carried in load_op[1:0]
//   LD_UNS_BIT    - index of the "unsigned" bit in load_op
//   MAX_OUTST_DEF - default depth of the cancelled-response counter
package me_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10,
    LD_D = 2'b11
  } ld_size_e;

  localparam int LD_UNS_BIT    = 2;
  localparam int MAX_OUTST_DEF = 2;

endpackage

// File: rtl/me_stage_nb_if.sv
// me_stage_nb_if: EX -> ME pipeline link.
//   master (EX side): drives ex_valid and the instruction fields, sees me_allow_in
//   slave  (ME side): receives the instruction fields, drives me_allow_in
interface me_stage_nb_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEST_W = 5
);
  localparam int AW = $clog2(DATA_W / 8);

  logic              ex_valid;
  logic              me_allow_in;
  logic [PC_W-1:0]   ex_pc;
  logic [DATA_W-1:0] ex_result;
  logic              ex_res_from_mem;
  logic              ex_gr_we;
  logic [DEST_W-1:0] ex_dest;
  logic [2:0]        ex_load_op;
  logic [AW-1:0]     ex_addr_lo;
  logic              ex_req_sent;
  logic              ex_req_fire;
  logic              ex_sys_op;

  modport master (
    output ex_valid, ex_pc, ex_result, ex_res_from_mem, ex_gr_we, ex_dest,
           ex_load_op, ex_addr_lo, ex_req_sent, ex_req_fire, ex_sys_op,
    input  me_allow_in
  );

  modport slave (
    input  ex_valid, ex_pc, ex_result, ex_res_from_mem, ex_gr_we, ex_dest,
           ex_load_op, ex_addr_lo, ex_req_sent, ex_req_fire, ex_sys_op,
    output me_allow_in
  );

endinterface

// File: rtl/me_stage_nb_load_align.sv
// load_align: combinational load-data lane select and extension.
//   raw      - full-width response word
//   addr_lo  - byte offset inside the word
//   load_op  - [2] unsigned, [1:0] size (b/h/w/d)
//   res      - selected lane, zero- or sign-extended to DATA_W
// A dword request on a 32-bit datapath is treated as a word.
module load_align
  import me_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [AW-1:0]     addr_lo,
  input  logic [2:0]        load_op,
  output logic [DATA_W-1:0] res
);

  ld_size_e          size;
  logic [AW-1:0]     off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              ext;

  always_comb begin
    size = ld_size_e'(load_op[1:0]);
    if (DATA_W == 32 && size == LD_D) size = LD_W;

    off     = '0;
    keep    = '1;
    shifted = '0;
    ext     = 1'b0;

    // lane offset is addr_lo rounded down to the access size
    case (size)
      LD_B:    off = addr_lo;
      LD_H:    off = addr_lo & ~AW'(1);
      LD_W:    off = addr_lo & ~AW'(3);
      default: off = '0;
    endcase

    shifted = raw >> {off, 3'b000};

    case (size)
      LD_B: begin
        keep = DATA_W'(8'hFF);
        ext  = shifted[7];
      end
      LD_H: begin
        keep = DATA_W'(16'hFFFF);
        ext  = shifted[15];
      end
      LD_W: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        ext  = shifted[31];
      end
      default: begin
        keep = '1;
        ext  = 1'b0;
      end
    endcase

    ext = ext & ~load_op[LD_UNS_BIT];
    res = (shifted & keep) | ({DATA_W{ext}} & ~keep);
  end

endmodule

// File: rtl/me_stage_nb.sv
// me_stage_nb: memory-access stage between EX and WB for a variable-latency
// data SRAM (req/addr_ok/data_ok).
//   clk, reset       - clock, synchronous active-high reset
//   ex               - EX -> ME link (me_stage_nb_if.slave)
//   data_sram_*      - response strobe and data
//   wb_allow_in      - WB back-pressure
//   flush            - exception/ertn flush; kills ME and counts orphaned requests
//   me_to_wb_*       - ME -> WB bundle
//   me_dest, me_fwd_res, me_fwd_ready, me_sys_op - hazard/forwarding taps
// Optional: ME_PERF_CNT_EN adds perf_wait_cnt (stall cycles) and
// perf_drop_cnt (discarded responses).
module me_stage_nb
  import me_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int DEST_W    = 5,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic              clk,
  input  logic              reset,
  me_stage_nb_if.slave      ex,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              wb_allow_in,
  input  logic              flush,
  output logic              me_to_wb_valid,
  output logic [PC_W-1:0]   me_to_wb_pc,
  output logic              me_to_wb_gr_we,
  output logic [DEST_W-1:0] me_to_wb_dest,
  output logic [DATA_W-1:0] me_to_wb_result,
  output logic [DEST_W-1:0] me_dest,
  output logic [DATA_W-1:0] me_fwd_res,
  output logic              me_fwd_ready,
  output logic              me_sys_op
`ifdef ME_PERF_CNT_EN
  ,
  output logic [31:0]       perf_wait_cnt,
  output logic [15:0]       perf_drop_cnt
`endif
);

  localparam int AW = $clog2(DATA_W / 8);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW+1:0] CNT_MAX = (CW + 2)'(MAX_OUTST);

  logic              valid;
  logic [PC_W-1:0]   pc_r;
  logic [DATA_W-1:0] result_r;
  logic              res_from_mem_r;
  logic              gr_we_r;
  logic [DEST_W-1:0] dest_r;
  logic [2:0]        load_op_r;
  logic [AW-1:0]     addr_lo_r;
  logic              req_sent_r;
  logic              sys_op_r;
  logic              data_got;
  logic [DATA_W-1:0] rdata_buf;
  logic [CW-1:0]     cancel_cnt;

  logic              cnt_zero, drop, pending, take, stall, ready_go, allow_in;
  logic [CW+1:0]     inc, cnt_sum;
  logic [CW-1:0]     cnt_next;
  logic [DATA_W-1:0] raw, extracted, final_res;

  assign cnt_zero = (cancel_cnt == '0);
  // responses come back in order, so anything owed to killed requests goes first
  assign drop     = data_sram_data_ok & ~cnt_zero;
  assign pending  = valid & req_sent_r & ~data_got;
  assign take     = data_sram_data_ok & cnt_zero & pending;
  assign stall    = pending & ~(data_sram_data_ok & cnt_zero);
  assign ready_go = ~stall;
  assign allow_in = ~valid | (ready_go & wb_allow_in);
  assign ex.me_allow_in = allow_in;

  // a flush orphans ME's own outstanding request plus any request EX fires now
  assign inc = flush ? ((CW + 2)'(pending & ~data_sram_data_ok) + (CW + 2)'(ex.ex_req_fire))
                     : '0;
  assign cnt_sum  = {2'b00, cancel_cnt} + inc - (CW + 2)'(drop);
  assign cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CW-1:0] : cnt_sum[CW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid          <= 1'b0;
      pc_r           <= '0;
      result_r       <= '0;
      res_from_mem_r <= 1'b0;
      gr_we_r        <= 1'b0;
      dest_r         <= '0;
      load_op_r      <= '0;
      addr_lo_r      <= '0;
      req_sent_r     <= 1'b0;
      sys_op_r       <= 1'b0;
      data_got       <= 1'b0;
      rdata_buf      <= '0;
      cancel_cnt     <= '0;
    end else begin
      cancel_cnt <= cnt_next;

      // our response arrived but WB is not taking the instruction: hold it
      if (take && !wb_allow_in) begin
        rdata_buf <= data_sram_rdata;
        data_got  <= 1'b1;
      end

      if (flush) begin
        valid    <= 1'b0;
        data_got <= 1'b0;
      end else if (ex.ex_valid && allow_in) begin
        valid          <= 1'b1;
        pc_r           <= ex.ex_pc;
        result_r       <= ex.ex_result;
        res_from_mem_r <= ex.ex_res_from_mem;
        gr_we_r        <= ex.ex_gr_we;
        dest_r         <= ex.ex_dest;
        load_op_r      <= ex.ex_load_op;
        addr_lo_r      <= ex.ex_addr_lo;
        req_sent_r     <= ex.ex_req_sent;
        sys_op_r       <= ex.ex_sys_op;
        data_got       <= 1'b0;
      end else if (allow_in) begin
        valid    <= 1'b0;
        data_got <= 1'b0;
      end
    end
  end

  assign raw = data_got ? rdata_buf : data_sram_rdata;

  load_align #(
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_load_align (
    .raw     (raw),
    .addr_lo (addr_lo_r),
    .load_op (load_op_r),
    .res     (extracted)
  );

  assign final_res = res_from_mem_r ? extracted : result_r;

  assign me_to_wb_valid  = valid & ready_go;
  assign me_to_wb_pc     = pc_r;
  assign me_to_wb_gr_we  = gr_we_r;
  assign me_to_wb_dest   = dest_r;
  assign me_to_wb_result = final_res;
  assign me_dest         = dest_r & {DEST_W{valid & gr_we_r}};
  assign me_fwd_res      = final_res & {DATA_W{gr_we_r}};
  assign me_fwd_ready    = ~(valid & stall & res_from_mem_r);
  assign me_sys_op       = sys_op_r & valid;

`ifdef ME_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_wait_cnt <= '0;
      perf_drop_cnt <= '0;
    end else begin
      if (valid && stall) perf_wait_cnt <= perf_wait_cnt + 32'd1;
      if (drop)           perf_drop_cnt <= perf_drop_cnt + 16'd1;
    end
  end
`endif

  a_resp_owned: assert property (@(posedge clk) disable iff (reset)
    data_sram_data_ok |-> (drop | pending));

  a_cancel_ovf: assert property (@(posedge clk) disable iff (reset)
    cnt_sum <= CNT_MAX);

endmodule

// File: tb/tb_me_stage_nb.sv
// tb_me_stage_nb: directed bench for me_stage_nb with a 32-bit and a 64-bit
// instance; expected values are hand-computed constants.
module tb_me_stage_nb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  me_stage_nb_if #(.DATA_W(32), .PC_W(32), .DEST_W(5)) ea ();
  me_stage_nb_if #(.DATA_W(64), .PC_W(32), .DEST_W(5)) eb ();

  logic        a_ok, a_wb_allow, a_flush;
  logic [31:0] a_rdata;
  logic        a_to_wb_valid, a_gr_we, a_fwd_ready, a_sys_op;
  logic [31:0] a_pc, a_result, a_fwd_res;
  logic [4:0]  a_dest, a_me_dest;

  logic        b_ok, b_wb_allow, b_flush;
  logic [63:0] b_rdata;
  logic        b_to_wb_valid, b_gr_we, b_fwd_ready, b_sys_op;
  logic [31:0] b_pc;
  logic [63:0] b_result, b_fwd_res;
  logic [4:0]  b_dest, b_me_dest;

`ifdef ME_PERF_CNT_EN
  logic [31:0] a_perf_wait, b_perf_wait;
  logic [15:0] a_perf_drop, b_perf_drop;
`endif

  me_stage_nb #(.DATA_W(32), .PC_W(32), .DEST_W(5), .MAX_OUTST(2)) u_a (
    .clk               (clk),
    .reset             (reset),
    .ex                (ea),
    .data_sram_data_ok (a_ok),
    .data_sram_rdata   (a_rdata),
    .wb_allow_in       (a_wb_allow),
    .flush             (a_flush),
    .me_to_wb_valid    (a_to_wb_valid),
    .me_to_wb_pc       (a_pc),
    .me_to_wb_gr_we    (a_gr_we),
    .me_to_wb_dest     (a_dest),
    .me_to_wb_result   (a_result),
    .me_dest           (a_me_dest),
    .me_fwd_res        (a_fwd_res),
    .me_fwd_ready      (a_fwd_ready),
    .me_sys_op         (a_sys_op)
`ifdef ME_PERF_CNT_EN
    ,
    .perf_wait_cnt     (a_perf_wait),
    .perf_drop_cnt     (a_perf_drop)
`endif
  );

  me_stage_nb #(.DATA_W(64), .PC_W(32), .DEST_W(5), .MAX_OUTST(2)) u_b (
    .clk               (clk),
    .reset             (reset),
    .ex                (eb),
    .data_sram_data_ok (b_ok),
    .data_sram_rdata   (b_rdata),
    .wb_allow_in       (b_wb_allow),
    .flush             (b_flush),
    .me_to_wb_valid    (b_to_wb_valid),
    .me_to_wb_pc       (b_pc),
    .me_to_wb_gr_we    (b_gr_we),
    .me_to_wb_dest     (b_dest),
    .me_to_wb_result   (b_result),
    .me_dest           (b_me_dest),
    .me_fwd_res        (b_fwd_res),
    .me_fwd_ready      (b_fwd_ready),
    .me_sys_op         (b_sys_op)
`ifdef ME_PERF_CNT_EN
    ,
    .perf_wait_cnt     (b_perf_wait),
    .perf_drop_cnt     (b_perf_drop)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_ex(input logic v, input logic [31:0] pc, input logic [31:0] res,
                      input logic rfm, input logic we, input logic [4:0] dest,
                      input logic [2:0] op, input logic [1:0] lo, input logic rs,
                      input logic sys);
    ea.ex_valid = v; ea.ex_pc = pc; ea.ex_result = res; ea.ex_res_from_mem = rfm;
    ea.ex_gr_we = we; ea.ex_dest = dest; ea.ex_load_op = op; ea.ex_addr_lo = lo;
    ea.ex_req_sent = rs; ea.ex_req_fire = 1'b0; ea.ex_sys_op = sys;
  endtask

  task automatic b_ex(input logic v, input logic [31:0] pc, input logic [63:0] res,
                      input logic rfm, input logic we, input logic [4:0] dest,
                      input logic [2:0] op, input logic [2:0] lo, input logic rs);
    eb.ex_valid = v; eb.ex_pc = pc; eb.ex_result = res; eb.ex_res_from_mem = rfm;
    eb.ex_gr_we = we; eb.ex_dest = dest; eb.ex_load_op = op; eb.ex_addr_lo = lo;
    eb.ex_req_sent = rs; eb.ex_req_fire = 1'b0; eb.ex_sys_op = 1'b0;
  endtask

  task automatic a_idle();
    a_ex(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic b_idle();
    b_ex(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    a_idle(); b_idle();
    a_ok = 0; a_rdata = '0; a_wb_allow = 1; a_flush = 0;
    b_ok = 0; b_rdata = '0; b_wb_allow = 1; b_flush = 0;
    repeat (2) @(posedge clk);

    // reset state
    @(negedge clk); #1;
    chk("rst_valid",     a_to_wb_valid, 0);
    chk("rst_allow",     ea.me_allow_in, 1);
    chk("rst_fwd_ready", a_fwd_ready, 1);
    chk("rst_result",    a_result, 0);
    chk("rst_me_dest",   a_me_dest, 0);
    chk("rst_b_allow",   eb.me_allow_in, 1);
    reset = 1'b0;

    // ld.b addr_lo=3, response 3 cycles after entry
    @(negedge clk); a_ex(1, 32'h100, 32'h1003, 1, 1, 5, 3'b000, 2'd3, 1, 0);
    @(negedge clk); a_idle(); #1;
    chk("t1_stall0",     a_to_wb_valid, 0);
    chk("t1_allow",      ea.me_allow_in, 0);
    chk("t1_fwd_wait",   a_fwd_ready, 0);
    @(negedge clk); #1; chk("t1_stall1", a_to_wb_valid, 0);
    @(negedge clk); #1; chk("t1_stall2", a_to_wb_valid, 0);
    @(negedge clk); a_ok = 1; a_rdata = 32'h80FF_1234; #1;
    chk("t1_valid",      a_to_wb_valid, 1);
    chk("t1_result",     a_result, 32'hFFFF_FF80);
    chk("t1_me_dest",    a_me_dest, 5);
    chk("t1_fwd_ready",  a_fwd_ready, 1);
    @(negedge clk); a_ok = 0; #1;
    chk("t1_gone",       a_to_wb_valid, 0);

    // ld.hu addr_lo=2 with WB stalled while the response arrives
    @(negedge clk); a_ex(1, 32'h104, 32'h2002, 1, 1, 6, 3'b101, 2'd2, 1, 0);
    @(negedge clk); a_idle(); a_ok = 1; a_rdata = 32'hBEEF_0000; a_wb_allow = 0; #1;
    chk("t2_valid",      a_to_wb_valid, 1);
    chk("t2_allow0",     ea.me_allow_in, 0);
    chk("t2_result0",    a_result, 32'h0000_BEEF);
    @(negedge clk); a_ok = 0; a_rdata = 32'hDEAD_DEAD; #1;
    chk("t2_allow1",     ea.me_allow_in, 0);
    chk("t2_buf_result", a_result, 32'h0000_BEEF);
    chk("t2_buf_valid",  a_to_wb_valid, 1);
    @(negedge clk); a_wb_allow = 1; #1;
    chk("t2_accept",     ea.me_allow_in, 1);
    chk("t2_acc_result", a_result, 32'h0000_BEEF);
    @(negedge clk); #1;
    chk("t2_gone",       a_to_wb_valid, 0);

    // flush while waiting with a request firing in EX: two responses owed
    @(negedge clk); a_ex(1, 32'h108, 32'h3000, 1, 1, 7, 3'b010, 2'd0, 1, 0);
    @(negedge clk); a_idle(); a_flush = 1; ea.ex_req_fire = 1; #1;
    chk("t3_pre_flush",  a_to_wb_valid, 0);
    @(negedge clk); a_flush = 0; ea.ex_req_fire = 0; #1;
    chk("t3_flushed",    a_to_wb_valid, 0);
    chk("t3_fl_allow",   ea.me_allow_in, 1);
    a_ex(1, 32'h10C, 32'h3004, 1, 1, 9, 3'b010, 2'd0, 1, 0);
    @(negedge clk); a_idle(); a_ok = 1; a_rdata = 32'h1111_1111; #1;
    chk("t3_drop1",      a_to_wb_valid, 0);
    chk("t3_drop1_allow", ea.me_allow_in, 0);
    @(negedge clk); a_rdata = 32'h2222_2222; #1;
    chk("t3_drop2",      a_to_wb_valid, 0);
    @(negedge clk); a_rdata = 32'h1234_5678; #1;
    chk("t3_new_valid",  a_to_wb_valid, 1);
    chk("t3_new_result", a_result, 32'h1234_5678);
    @(negedge clk); a_ok = 0; #1;
    chk("t3_gone",       a_to_wb_valid, 0);

    // back-to-back ALU ops
    @(negedge clk); a_ex(1, 32'h200, 32'hA1, 0, 1, 8, 3'b000, 2'd0, 0, 0);
    @(negedge clk); a_ex(1, 32'h204, 32'hA2, 0, 0, 9, 3'b000, 2'd0, 0, 1); #1;
    chk("t4_v1",         a_to_wb_valid, 1);
    chk("t4_res1",       a_result, 32'hA1);
    chk("t4_pc1",        a_pc, 32'h200);
    chk("t4_allow1",     ea.me_allow_in, 1);
    chk("t4_fwd_rdy1",   a_fwd_ready, 1);
    chk("t4_fwd_res1",   a_fwd_res, 32'hA1);
    chk("t4_me_dest1",   a_me_dest, 8);
    @(negedge clk); a_ex(1, 32'h208, 32'hA3, 0, 1, 10, 3'b000, 2'd0, 0, 0); #1;
    chk("t4_v2",         a_to_wb_valid, 1);
    chk("t4_res2",       a_result, 32'hA2);
    chk("t4_pc2",        a_pc, 32'h204);
    chk("t4_me_dest2",   a_me_dest, 0);
    chk("t4_fwd_res2",   a_fwd_res, 0);
    chk("t4_sys2",       a_sys_op, 1);
    @(negedge clk); a_idle(); #1;
    chk("t4_v3",         a_to_wb_valid, 1);
    chk("t4_res3",       a_result, 32'hA3);
    chk("t4_sys3",       a_sys_op, 0);
    @(negedge clk); #1;
    chk("t4_gone",       a_to_wb_valid, 0);

    // 64-bit datapath loads
    @(negedge clk); b_ex(1, 32'h300, 64'h1004, 1, 1, 3, 3'b010, 3'd4, 1);
    @(negedge clk); b_idle(); b_ok = 1; b_rdata = 64'h8000_0001_0000_0000; #1;
    chk("t5_w_valid",    b_to_wb_valid, 1);
    chk("t5_w_result",   b_result, 64'hFFFF_FFFF_8000_0001);
    @(negedge clk); b_ok = 0; b_ex(1, 32'h304, 64'h1000, 1, 1, 4, 3'b011, 3'd0, 1);
    @(negedge clk); b_idle(); b_ok = 1; b_rdata = 64'h0123_4567_89AB_CDEF; #1;
    chk("t5_d_result",   b_result, 64'h0123_4567_89AB_CDEF);
    @(negedge clk); b_ok = 0; b_ex(1, 32'h308, 64'h1007, 1, 1, 5, 3'b100, 3'd7, 1);
    @(negedge clk); b_idle(); b_ok = 1; b_rdata = 64'hAB00_0000_0000_0000; #1;
    chk("t5_bu_result",  b_result, 64'h0000_0000_0000_00AB);
    @(negedge clk); b_ok = 0;

    // reset while waiting with one cancelled response owed
    @(negedge clk); a_ex(1, 32'h400, 32'h4000, 1, 1, 11, 3'b010, 2'd0, 1, 1);
    @(negedge clk); a_idle(); a_flush = 1; #1;
    chk("t6_wait0",      a_to_wb_valid, 0);
    @(negedge clk); a_flush = 0; a_ex(1, 32'h404, 32'h4004, 1, 1, 12, 3'b010, 2'd0, 1, 1);
    @(negedge clk); a_idle(); reset = 1; #1;
    chk("t6_pre_fwd",    a_fwd_ready, 0);
    chk("t6_pre_dest",   a_me_dest, 12);
    chk("t6_pre_sys",    a_sys_op, 1);
    @(negedge clk); reset = 0; #1;
    chk("t6_valid",      a_to_wb_valid, 0);
    chk("t6_allow",      ea.me_allow_in, 1);
    chk("t6_fwd_ready",  a_fwd_ready, 1);
    chk("t6_result",     a_result, 0);
    chk("t6_me_dest",    a_me_dest, 0);
    chk("t6_sys",        a_sys_op, 0);
    chk("t6_pc",         a_pc, 0);
    chk("t6_dest",       a_dest, 0);
    chk("t6_gr_we",      a_gr_we, 0);
    chk("t6_fwd_res",    a_fwd_res, 0);
    @(negedge clk); a_ex(1, 32'h408, 32'h4008, 1, 1, 13, 3'b010, 2'd0, 1, 0);
    @(negedge clk); a_idle(); a_ok = 1; a_rdata = 32'hCAFE_F00D; #1;
    chk("t6_cnt_clr",    a_to_wb_valid, 1);
    chk("t6_new_result", a_result, 32'hCAFE_F00D);
    @(negedge clk); a_ok = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
